// File: rtl/lanzones_regfile_if.sv
// Decode/writeback/issue bus of the lanzones register file.
// The master side is the pipeline; the slave side is the register file.
interface lanzones_regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                iss_rdy;
  logic                flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, iss_rdy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, iss_rdy
  );
endinterface

// File: rtl/lanzones_regfile.sv
// RV32 integer register file with a write-pending scoreboard gating issue.
// Define LANZONES_RF_BYPASS_EN to forward the writeback port onto the read ports.
module lanzones_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                rst,
  lanzones_regfile_if.slave   bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS-1:1];
  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_d;
  logic [NREGS-1:0] busy_full;
  logic             wr_live;
  logic             iss_rdy;

  // x0 has no storage: bit 0 of the widened vector is tied low
  assign busy_full = {busy_q, 1'b0};
  assign wr_live   = bus.wr_en && (bus.wr_addr != '0);

  assign iss_rdy = !bus.flush &&
                   ((bus.iss_addr == '0) || !busy_full[bus.iss_addr] ||
                    (bus.wr_en && (bus.wr_addr == bus.iss_addr)));
  assign bus.iss_rdy = iss_rdy;

  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (wr_live) busy_d[bus.wr_addr] = 1'b0;
      if (bus.iss_en && iss_rdy && (bus.iss_addr != '0)) busy_d[bus.iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++) regs_q[r] <= '0;
    end else if (wr_live) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] stored;
    logic            stored_busy;

    assign ra          = bus.rd_addr[i*AW +: AW];
    assign stored      = (ra == '0) ? '0 : regs_q[ra];
    assign stored_busy = busy_full[ra];

`ifdef LANZONES_RF_BYPASS_EN
    logic hit;
    assign hit = wr_live && (bus.wr_addr == ra);
    assign bus.rd_data[i*XLEN +: XLEN] = hit ? bus.wr_data : stored;
    assign bus.rd_busy[i]              = hit ? 1'b0 : stored_busy;
`else
    assign bus.rd_data[i*XLEN +: XLEN] = stored;
    assign bus.rd_busy[i]              = stored_busy;
`endif
  end
endmodule

// File: tb/tb_lanzones_regfile.sv
// Directed testbench for lanzones_regfile (XLEN=32, NREGS=32, NRD=2).
module tb_lanzones_regfile;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lanzones_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  lanzones_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.wr_en  = 1'b0;
    bus.iss_en = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic test_reset;
    bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.iss_addr = '0;
    idle();
    set_rd(5'd7, 5'd5);
    #3;
    checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", bus.rd_data); end
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy got %b exp 00", bus.rd_busy); end
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL reset_iss_rdy got %b exp 1", bus.iss_rdy); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
    tick();
    idle();
    set_rd(5'd0, 5'd5);
    #1;
    checks++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_x5 got %h exp deadbeef", bus.rd_data[31:0]); end
    checks++; if (bus.rd_data[63:32] !== 32'h0) begin errors++; $display("FAIL rd_x0 got %h exp 0", bus.rd_data[63:32]); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    #1;
    checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL wr_x0_dropped got %h exp 0", bus.rd_data); end
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL x0_busy got %b exp 00", bus.rd_busy); end
  endtask

  task automatic test_issue_stall;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    #1;
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL iss_x7_first got %b exp 1", bus.iss_rdy); end
    tick();
    set_rd(5'd0, 5'd7);
    #1;
    checks++; if (bus.iss_rdy !== 1'b0) begin errors++; $display("FAIL iss_x7_second got %b exp 0", bus.iss_rdy); end
    checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL busy_x7 got %b exp 1", bus.rd_busy[0]); end
    bus.iss_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h55;
    tick();
    idle();
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wb_x7_busy got %b exp 0", bus.rd_busy[0]); end
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL wb_x7_rdy got %b exp 1", bus.iss_rdy); end
    checks++; if (bus.rd_data[31:0] !== 32'h55) begin errors++; $display("FAIL wb_x7_data got %h exp 55", bus.rd_data[31:0]); end
  endtask

  task automatic test_issue_writeback_same;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'hA5;
    #1;
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL iss_wb_x9_rdy got %b exp 1", bus.iss_rdy); end
    tick();
    idle();
    set_rd(5'd0, 5'd9);
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL iss_wb_x9_busy got %b exp 1", bus.rd_busy[0]); end
    checks++; if (bus.rd_data[31:0] !== 32'hA5) begin errors++; $display("FAIL iss_wb_x9_data got %h exp a5", bus.rd_data[31:0]); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'hA5;
    tick();
    idle();
  endtask

  task automatic test_bypass;
    logic [31:0] exp_d;
    logic        exp_b;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
    tick();
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h77;
    set_rd(5'd3, 5'd0);
`ifdef LANZONES_RF_BYPASS_EN
    exp_d = 32'h77; exp_b = 1'b0;
`else
    exp_d = 32'h0;  exp_b = 1'b1;
`endif
    #1;
    checks++; if (bus.rd_data[63:32] !== exp_d) begin errors++; $display("FAIL same_cycle_x3_data got %h exp %h", bus.rd_data[63:32], exp_d); end
    checks++; if (bus.rd_busy[1] !== exp_b) begin errors++; $display("FAIL same_cycle_x3_busy got %b exp %b", bus.rd_busy[1], exp_b); end
    tick();
    idle();
    #1;
    checks++; if (bus.rd_data[63:32] !== 32'h77) begin errors++; $display("FAIL after_x3_data got %h exp 77", bus.rd_data[63:32]); end
    checks++; if (bus.rd_busy[1] !== 1'b0) begin errors++; $display("FAIL after_x3_busy got %b exp 0", bus.rd_busy[1]); end
  endtask

  task automatic test_flush;
    bus.iss_en = 1'b1;
    bus.iss_addr = 5'd1;  tick();
    bus.iss_addr = 5'd2;  tick();
    bus.iss_addr = 5'd31; tick();
    idle();
    set_rd(5'd31, 5'd1);
    #1;
    checks++; if (bus.rd_busy !== 2'b11) begin errors++; $display("FAIL pre_flush_busy got %b exp 11", bus.rd_busy); end
    bus.flush = 1'b1; bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h99;
    #1;
    checks++; if (bus.iss_rdy !== 1'b0) begin errors++; $display("FAIL flush_iss_rdy got %b exp 0", bus.iss_rdy); end
    tick();
    idle();
    #1;
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL post_flush_x1_x31 got %b exp 00", bus.rd_busy); end
    set_rd(5'd4, 5'd2);
    #1;
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL post_flush_x2_x4 got %b exp 00", bus.rd_busy); end
    checks++; if (bus.rd_data[31:0] !== 32'h99) begin errors++; $display("FAIL flush_write_lands got %h exp 99", bus.rd_data[31:0]); end
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL post_flush_rdy_x4 got %b exp 1", bus.iss_rdy); end
  endtask

  task automatic test_async_reset;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd10;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'h42;
    tick();
    idle();
    set_rd(5'd5, 5'd10);
    #1;
    checks++; if (bus.rd_data[31:0] !== 32'h42) begin errors++; $display("FAIL pre_rst_x10_data got %h exp 42", bus.rd_data[31:0]); end
    checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_x10_busy got %b exp 1", bus.rd_busy[0]); end
    bus.iss_addr = 5'd10;
    rst = 1'b1;
    #1;
    checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL async_rst_data got %h exp 0", bus.rd_data); end
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL async_rst_busy got %b exp 00", bus.rd_busy); end
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL async_rst_rdy got %b exp 1", bus.iss_rdy); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL post_rst_data got %h exp 0", bus.rd_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_issue_stall();
    test_issue_writeback_same();
    test_bypass();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
